// File: rtl/pulse_stretch_pkg.sv
// Shared types for the pulse stretcher: FSM state encoding and counter sizing.
package pulse_stretch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HOLD = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  // One counter serves both phases, so it must hold the larger reload value.
  function automatic int cnt_width(input int hold, input int gap);
    return $clog2(((hold > gap) ? hold : gap) + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_if.sv
// Event-in / window-out bundle; master drives the strobe side, slave is the stretcher.
interface pulse_stretch_if #(
  parameter int PEND_W = 3
);
  logic              pulse;
  logic              overflow_clr;
  logic              level;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  modport master (output pulse, overflow_clr, input level, busy, pending, overflow);
  modport slave  (input pulse, overflow_clr, output level, busy, pending, overflow);
endinterface

// File: rtl/pulse_stretch_down_counter.sv
// Loadable down counter shared by the HOLD and GAP phases; zero flags the final cycle.
// One cycle from load/en to count; load takes priority over en.
module down_counter #(
  parameter int W = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretch.sv
// Stretches single-cycle strobes into HOLD_CYCLES-wide windows separated by GAP_CYCLES lows.
// Zero-latency start from IDLE; events during a window are queued (or retrigger), never stalled.
module pulse_stretch
  import pulse_stretch_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3,
  parameter int RETRIGGER   = 0
) (
  input  logic            clock,
  input  logic            reset,
  pulse_stretch_if.slave  bus
);

  localparam int              CW       = cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0]   HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]   GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_MAX  = (HOLD_LD > GAP_LD) ? HOLD_LD : GAP_LD;
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t            state;
  logic              level_q;
  logic              busy_q;
  logic              ovf_q;
  logic [PEND_W-1:0] pend_q;

  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_zero;
  logic [CW-1:0]     cnt_val;
  logic [CW-1:0]     cnt_q;

  logic              retrig_hit;
  logic              enq;
  logic              deq;
  logic              ovf_set;

  assign retrig_hit = (RETRIGGER != 0) && bus.pulse && (state == ST_HOLD);
  assign enq        = bus.pulse && (((state == ST_HOLD) && (RETRIGGER == 0)) || (state == ST_GAP));
  // A strobe landing on the GAP expiry edge with nothing queued is consumed directly.
  assign deq        = (state == ST_GAP) && cnt_zero && ((pend_q != '0) || bus.pulse);
  assign ovf_set    = enq && !deq && (pend_q == PEND_MAX);

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = HOLD_LD;
    cnt_en   = 1'b0;
    case (state)
      ST_IDLE: cnt_load = bus.pulse;
      ST_HOLD: begin
        if (retrig_hit) begin
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = GAP_LD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_zero) cnt_load = deq;
        else          cnt_en   = 1'b1;
      end
      default: ;
    endcase
  end

  down_counter #(.W(CW)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .count    (cnt_q),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clock) begin
    if (!reset) assert (cnt_q <= CNT_MAX);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.pulse) begin
            state   <= ST_HOLD;
            level_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (!retrig_hit && cnt_zero) begin
            state   <= ST_GAP;
            level_q <= 1'b0;
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            if (deq) begin
              state   <= ST_HOLD;
              level_q <= 1'b1;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase

      if (enq && !deq) begin
        if (pend_q != PEND_MAX) pend_q <= pend_q + PEND_W'(1);
      end else if (deq && !enq) begin
        pend_q <= pend_q - PEND_W'(1);
      end

      if (ovf_set)               ovf_q <= 1'b1;
      else if (bus.overflow_clr) ovf_q <= 1'b0;
    end
  end

  assign bus.level    = level_q;
  assign bus.busy     = busy_q;
  assign bus.pending  = pend_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboarded bench for pulse_stretch: three instances (default, PEND_W=2, RETRIGGER=1).
module tb_pulse_stretch;

  typedef struct {
    int   idx;
    logic l;
    logic b;
    int   p;
    logic o;
  } exp_t;

  logic  clock = 1'b0;
  logic  reset = 1'b1;
  int    sel   = 0;
  string cur   = "init";
  int    n_checks = 0;
  int    n_errors = 0;
  exp_t  sb[$];

  logic [31:0] t_pul, t_lvl, t_bsy, t_ovf, t_rst, t_clr;
  int          t_p[32];

  pulse_stretch_if #(.PEND_W(3)) if0 ();
  pulse_stretch_if #(.PEND_W(2)) if1 ();
  pulse_stretch_if #(.PEND_W(3)) if2 ();

  pulse_stretch #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_W(3), .RETRIGGER(0)) u0 (
    .clock(clock), .reset(reset), .bus(if0));
  pulse_stretch #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_W(2), .RETRIGGER(0)) u1 (
    .clock(clock), .reset(reset), .bus(if1));
  pulse_stretch #(.HOLD_CYCLES(4), .GAP_CYCLES(2), .PEND_W(3), .RETRIGGER(1)) u2 (
    .clock(clock), .reset(reset), .bus(if2));

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  always @(negedge clock) begin
    exp_t        e;
    logic [31:0] ol, ob, op, oo;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      case (sel)
        0: begin ol = 32'(if0.level); ob = 32'(if0.busy); op = 32'(if0.pending); oo = 32'(if0.overflow); end
        1: begin ol = 32'(if1.level); ob = 32'(if1.busy); op = 32'(if1.pending); oo = 32'(if1.overflow); end
        default: begin ol = 32'(if2.level); ob = 32'(if2.busy); op = 32'(if2.pending); oo = 32'(if2.overflow); end
      endcase
      check_eq($sformatf("%s[e%0d].level", cur, e.idx), ol, 32'(e.l));
      check_eq($sformatf("%s[e%0d].busy", cur, e.idx), ob, 32'(e.b));
      check_eq($sformatf("%s[e%0d].pending", cur, e.idx), op, 32'(e.p));
      check_eq($sformatf("%s[e%0d].overflow", cur, e.idx), oo, 32'(e.o));
    end
  end

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic clear_tbl();
    t_pul = '0; t_lvl = '0; t_bsy = '0; t_ovf = '0; t_rst = '0; t_clr = '0;
    for (int i = 0; i < 32; i++) t_p[i] = 0;
  endtask

  task automatic set_p(input int lo, input int hi, input int v);
    for (int i = lo; i <= hi; i++) t_p[i] = v;
  endtask

  // Entry i of each table describes the edge that samples stimulus i.
  task automatic run(input string name, input int s, input int n);
    exp_t e;
    cur = name;
    sel = s;
    for (int i = 0; i < n; i++) begin
      if0.pulse = (s == 0) && t_pul[i];
      if1.pulse = (s == 1) && t_pul[i];
      if2.pulse = (s == 2) && t_pul[i];
      if0.overflow_clr = (s == 0) && t_clr[i];
      if1.overflow_clr = (s == 1) && t_clr[i];
      if2.overflow_clr = (s == 2) && t_clr[i];
      reset = t_rst[i];
      @(posedge clock);
      #1;
      e.idx = i; e.l = t_lvl[i]; e.b = t_bsy[i]; e.p = t_p[i]; e.o = t_ovf[i];
      sb.push_back(e);
    end
    if0.pulse = 1'b0; if1.pulse = 1'b0; if2.pulse = 1'b0;
    if0.overflow_clr = 1'b0; if1.overflow_clr = 1'b0; if2.overflow_clr = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    #1;
  endtask

  initial begin
    if0.pulse = 1'b0; if1.pulse = 1'b0; if2.pulse = 1'b0;
    if0.overflow_clr = 1'b0; if1.overflow_clr = 1'b0; if2.overflow_clr = 1'b0;

    for (int s = 0; s < 3; s++) begin
      clear_tbl();
      t_rst = rng(0, 1);
      run("reset", s, 2);
    end

    clear_tbl();
    t_pul = rng(0, 0); t_lvl = rng(0, 3); t_bsy = rng(0, 5);
    run("single", 0, 9);

    clear_tbl();
    t_pul = rng(0, 2); t_lvl = rng(0, 3) | rng(6, 9) | rng(12, 15); t_bsy = rng(0, 17);
    set_p(1, 1, 1); set_p(2, 5, 2); set_p(6, 11, 1);
    run("burst3", 0, 20);

    clear_tbl();
    t_pul = rng(0, 1) | rng(6, 6); t_lvl = rng(0, 3) | rng(6, 9) | rng(12, 15); t_bsy = rng(0, 17);
    set_p(1, 11, 1);
    run("gap_expiry_pulse", 0, 20);

    clear_tbl();
    t_pul = rng(0, 2); t_rst = rng(3, 3); t_lvl = rng(0, 2); t_bsy = rng(0, 2);
    set_p(1, 1, 1); set_p(2, 2, 2);
    run("mid_reset", 0, 5);

    // Drop at saturation on edge 4 while clear is also asserted: set must win there.
    clear_tbl();
    t_pul = rng(0, 4); t_clr = rng(4, 5);
    t_lvl = rng(0, 3) | rng(6, 9) | rng(12, 15) | rng(18, 21); t_bsy = rng(0, 23);
    t_ovf = rng(4, 4);
    set_p(1, 1, 1); set_p(2, 2, 2); set_p(3, 5, 3); set_p(6, 11, 2); set_p(12, 17, 1);
    run("overflow", 1, 26);

    clear_tbl();
    t_pul = rng(0, 0) | rng(3, 3); t_lvl = rng(0, 6); t_bsy = rng(0, 8);
    run("retrigger", 2, 11);

    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
